// File: rtl/cpu_bus_serializer.sv
// cpu_bus_serializer
//
// Purpose:
//   Divides clk by DIV to produce the CPU core clock. Each half-period is DIV
//   clk cycles long.
//   In each CPU clock half-period the block sends one frame on a narrow
//   output bus. A frame is a snapshotted ADDR_W-bit address followed by the
//   CTRL_W control bits, one OUT_W-bit slice per clk cycle. The slot and
//   frame tags let off-chip logic demultiplex the bus. The enable input
//   freezes the whole frame.
//
// Ports:
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   ena        in   1       1 = advance, 0 = freeze counter, CPU clock and outputs
//   addr_i     in   ADDR_W  CPU address (stable at phase 0)
//   ctrl_i     in   CTRL_W  CPU control bits (bit0 = RW, bit1 = SYNC)
//   cpu_clk_o  out  1       divided CPU clock
//   bus_o      out  OUT_W   multiplexed output slice
//   slot_o     out  CW      index of the slice currently on bus_o
//   frame_o    out  1       high while bus_o carries slot 0
//   valid_o    out  1       high while bus_o carries a fresh slice
//   par_o      out  1       even parity of bus_o (optional)
//
// Configuration:
//   BUS_PARITY_EN  When defined, par_o is the registered XOR of the slice on
//                  bus_o. When undefined, par_o is tied to 0.

module cpu_bus_serializer #(
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 16,
    parameter int CTRL_W = 2,
    parameter int DIV    = 3,
    localparam int NA    = (ADDR_W + OUT_W - 1) / OUT_W,
    localparam int NSLOT = NA + 1,
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              cpu_clk_o,
    output logic [OUT_W-1:0]  bus_o,
    output logic [CW-1:0]     slot_o,
    output logic              frame_o,
    output logic              valid_o,
    output logic              par_o
);

    // The padded address is NA whole slices wide. Slice 0 comes straight
    // from addr_i, so only the slices above it are kept in the snapshot.
    localparam int PADW   = NA * OUT_W;
    localparam int SNAP_W = (NA > 1) ? (PADW - OUT_W) : 1;

    // Every slot must fit inside one CPU clock half-period, and the control
    // bits must fit in one slice.
    if (DIV < NSLOT) begin : g_div_check
        $error("cpu_bus_serializer: DIV must be >= NSLOT");
    end
    if (CTRL_W > OUT_W) begin : g_ctrl_check
        $error("cpu_bus_serializer: CTRL_W must be <= OUT_W");
    end

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cpu_clk_q, cpu_clk_d;
    logic [OUT_W-1:0]  bus_q, bus_d;
    logic [CW-1:0]     slot_q, slot_d;
    logic              frame_q, frame_d;
    logic              valid_q, valid_d;
    logic [SNAP_W-1:0] snap_addr_q, snap_addr_d;
    logic [CTRL_W-1:0] snap_ctrl_q, snap_ctrl_d;

    logic [PADW-1:0]   addr_pad;
    logic [SNAP_W-1:0] snap_src;
    logic [OUT_W-1:0]  slice_data;
    logic              phase_zero;
    logic              phase_last;
    logic              phase_active;

    assign addr_pad = PADW'(addr_i);

    if (NA > 1) begin : g_snap_src
        assign snap_src = addr_pad[PADW-1:OUT_W];
    end else begin : g_no_snap_src
        assign snap_src = '0;
    end

    // The compare runs one bit wider than cnt so that NSLOT == 2**CW is
    // still treated correctly.
    assign phase_zero   = (cnt_q == '0);
    assign phase_last   = (cnt_q == CW'(DIV - 1));
    assign phase_active = ({1'b0, cnt_q} < (CW + 1)'(NSLOT));

    // Slice mux. Slice 0 uses the live address because the snapshot is
    // loaded on the same edge. Later slices use the snapshot, so a change
    // on addr_i in mid-frame cannot tear the frame.
    always_comb begin
        slice_data = '0;
        if (phase_zero) begin
            slice_data = addr_pad[OUT_W-1:0];
        end else if (cnt_q == CW'(NA)) begin
            slice_data = OUT_W'(snap_ctrl_q);
        end else begin
            for (int k = 1; k < NA; k++) begin
                if (cnt_q == CW'(k)) begin
                    slice_data = snap_addr_q[(k-1)*OUT_W +: OUT_W];
                end
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        cpu_clk_d   = cpu_clk_q;
        bus_d       = bus_q;
        slot_d      = slot_q;
        frame_d     = frame_q;
        valid_d     = valid_q;
        snap_addr_d = snap_addr_q;
        snap_ctrl_d = snap_ctrl_q;
        if (ena) begin
            cnt_d = phase_last ? '0 : cnt_q + 1'b1;
            if (phase_last) begin
                cpu_clk_d = ~cpu_clk_q;
            end
            if (phase_zero) begin
                snap_addr_d = snap_src;
                snap_ctrl_d = ctrl_i;
            end
            // In idle phases the bus and slot keep their last value. Only
            // the qualifiers drop.
            if (phase_active) begin
                bus_d   = slice_data;
                slot_d  = cnt_q;
                valid_d = 1'b1;
                frame_d = phase_zero;
            end else begin
                valid_d = 1'b0;
                frame_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cpu_clk_q   <= 1'b0;
            bus_q       <= '0;
            slot_q      <= '0;
            frame_q     <= 1'b0;
            valid_q     <= 1'b0;
            snap_addr_q <= '0;
            snap_ctrl_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cpu_clk_q   <= cpu_clk_d;
            bus_q       <= bus_d;
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            valid_q     <= valid_d;
            snap_addr_q <= snap_addr_d;
            snap_ctrl_q <= snap_ctrl_d;
        end
    end

`ifdef BUS_PARITY_EN
    logic par_q, par_d;

    // Parity follows bus_o. It changes only when a fresh slice is loaded.
    always_comb begin
        par_d = par_q;
        if (ena && phase_active) begin
            par_d = ^slice_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_o = par_q;
`else
    assign par_o = 1'b0;
`endif

    assign cpu_clk_o = cpu_clk_q;
    assign bus_o     = bus_q;
    assign slot_o    = slot_q;
    assign frame_o   = frame_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// tb_cpu_bus_serializer
//
// Bench for cpu_bus_serializer. It uses two instances:
//   u_dut_a  default parameters (ADDR_W=16, DIV=3), no idle phase
//   u_dut_b  ADDR_W=12, DIV=4, one idle phase per half-period
// The reference model counts enabled clock edges since reset. The phase is
// that count modulo DIV. The CPU clock level is (count / DIV) mod 2. A frame
// is the address and control captured at phase 0, cut into bytes.

module tb_cpu_bus_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] addr_a;
    logic [1:0]  ctrl_a;
    logic [11:0] addr_b;
    logic [1:0]  ctrl_b;

    logic        cpu_clk_a, frame_a, valid_a, par_a;
    logic [7:0]  bus_a;
    logic [1:0]  slot_a;
    logic        cpu_clk_b, frame_b, valid_b, par_b;
    logic [7:0]  bus_b;
    logic [1:0]  slot_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_bus_serializer u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .addr_i    (addr_a),
        .ctrl_i    (ctrl_a),
        .cpu_clk_o (cpu_clk_a),
        .bus_o     (bus_a),
        .slot_o    (slot_a),
        .frame_o   (frame_a),
        .valid_o   (valid_a),
        .par_o     (par_a)
    );

    cpu_bus_serializer #(.OUT_W(8), .ADDR_W(12), .CTRL_W(2), .DIV(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .addr_i    (addr_b),
        .ctrl_i    (ctrl_b),
        .cpu_clk_o (cpu_clk_b),
        .bus_o     (bus_b),
        .slot_o    (slot_b),
        .frame_o   (frame_b),
        .valid_o   (valid_b),
        .par_o     (par_b)
    );

    // Reference model state, index 0 = instance A, index 1 = instance B.
    int          m_n[2];
    int          m_div[2] = '{3, 4};
    int          m_na[2]  = '{2, 2};
    logic [15:0] m_faddr[2];
    logic [1:0]  m_fctrl[2];
    logic [7:0]  e_bus[2];
    int          e_slot[2];
    logic        e_frame[2];
    logic        e_valid[2];
    logic        e_par[2];
    logic        e_cpu[2];

    function automatic logic [7:0] model_slice(logic [15:0] a, logic [1:0] c, int k, int na);
        if (k < na) return 8'(a >> (k * 8));
        return {6'b0, c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]     = 0;
            m_faddr[i] = '0;
            m_fctrl[i] = '0;
            e_bus[i]   = '0;
            e_slot[i]  = 0;
            e_frame[i] = 1'b0;
            e_valid[i] = 1'b0;
            e_par[i]   = 1'b0;
            e_cpu[i]   = 1'b0;
        end
    endtask

    task automatic model_edge(int i, logic [15:0] a, logic [1:0] c);
        int ph;
        logic [7:0] s;
        if (!rst_n || !ena) return;
        ph = m_n[i] % m_div[i];
        if (ph == 0) begin
            m_faddr[i] = a;
            m_fctrl[i] = c;
        end
        if (ph <= m_na[i]) begin
            s = model_slice(m_faddr[i], m_fctrl[i], ph, m_na[i]);
            e_bus[i]   = s;
            e_slot[i]  = ph;
            e_valid[i] = 1'b1;
            e_frame[i] = (ph == 0);
`ifdef BUS_PARITY_EN
            e_par[i]   = ^s;
`endif
        end else begin
            e_valid[i] = 1'b0;
            e_frame[i] = 1'b0;
        end
        m_n[i] = m_n[i] + 1;
        e_cpu[i] = ((m_n[i] / m_div[i]) % 2) == 1;
    endtask

    // One clock edge. The model sees the same inputs as the DUT, and the
    // outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge(0, addr_a, ctrl_a);
        model_edge(1, {4'b0, addr_b}, ctrl_b);
        #1;
    endtask

    task automatic align_a();
        ena = 1'b1;
        while (m_n[0] % 3 != 0) tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b0;
        addr_a = 16'h5A5A;
        ctrl_a = 2'b11;
        addr_b = 12'hFFF;
        ctrl_b = 2'b11;
        model_reset();
        tick();
        tick();
        vectors++;
        if ({cpu_clk_a, bus_a, slot_a, frame_a, valid_a, par_a} !== 14'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_a got cpu=%b bus=%h slot=%0d frame=%b valid=%b par=%b want all 0",
                     cpu_clk_a, bus_a, slot_a, frame_a, valid_a, par_a);
        end
        vectors++;
        if ({cpu_clk_b, bus_b, slot_b, frame_b, valid_b, par_b} !== 14'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_b got cpu=%b bus=%h slot=%0d frame=%b valid=%b par=%b want all 0",
                     cpu_clk_b, bus_b, slot_b, frame_b, valid_b, par_b);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_frame();
        logic [7:0] seq_a[3] = '{8'hEF, 8'hBE, 8'h02};
        logic [7:0] seq_b[4] = '{8'hBC, 8'h0A, 8'h01, 8'h01};
        addr_a = 16'hBEEF;
        ctrl_a = 2'b10;
        addr_b = 12'hABC;
        ctrl_b = 2'b01;
        ena    = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            vectors++;
            if (bus_a !== seq_a[(t-1) % 3] || slot_a !== 2'((t-1) % 3) || frame_a !== ((t-1) % 3 == 0)) begin
                miscompares++;
                $display("[TB] FAIL frame_a t=%0d got bus=%h slot=%0d frame=%b want bus=%h slot=%0d frame=%b",
                         t, bus_a, slot_a, frame_a, seq_a[(t-1) % 3], (t-1) % 3, ((t-1) % 3 == 0));
            end
            vectors++;
            if (cpu_clk_a !== ((t / 3) % 2 == 1)) begin
                miscompares++;
                $display("[TB] FAIL cpuclk_a t=%0d got %b want %b", t, cpu_clk_a, ((t / 3) % 2 == 1));
            end
            vectors++;
            if (bus_b !== seq_b[(t-1) % 4] || valid_b !== ((t-1) % 4 != 3)) begin
                miscompares++;
                $display("[TB] FAIL frame_b t=%0d got bus=%h valid=%b want bus=%h valid=%b",
                         t, bus_b, valid_b, seq_b[(t-1) % 4], ((t-1) % 4 != 3));
            end
            vectors++;
            if (cpu_clk_b !== ((t / 4) % 2 == 1)) begin
                miscompares++;
                $display("[TB] FAIL cpuclk_b t=%0d got %b want %b", t, cpu_clk_b, ((t / 4) % 2 == 1));
            end
        end
    endtask

    task automatic test_snapshot();
        align_a();
        addr_a = 16'h1234;
        ctrl_a = 2'b00;
        tick();
        vectors++;
        if (bus_a !== 8'h34) begin
            miscompares++;
            $display("[TB] FAIL snap_slot0 got %h want 34", bus_a);
        end
        addr_a = 16'hFFFF;
        tick();
        vectors++;
        if (bus_a !== 8'h12 || slot_a !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL snap_slot1 got bus=%h slot=%0d want bus=12 slot=1", bus_a, slot_a);
        end
        tick();
        tick();
        vectors++;
        if (bus_a !== 8'hFF || frame_a !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL snap_next got bus=%h frame=%b want bus=ff frame=1", bus_a, frame_a);
        end
    endtask

    task automatic test_freeze();
        logic [7:0] hold_bus;
        logic       hold_cpu;
        align_a();
        addr_a = 16'hC3A5;
        ctrl_a = 2'b01;
        tick();
        tick();
        hold_bus = bus_a;
        hold_cpu = cpu_clk_a;
        vectors++;
        if (hold_bus !== 8'hC3) begin
            miscompares++;
            $display("[TB] FAIL freeze_pre got %h want c3", hold_bus);
        end
        ena    = 1'b0;
        addr_a = 16'h0000;
        ctrl_a = 2'b10;
        for (int t = 0; t < 5; t++) begin
            tick();
            vectors++;
            if (bus_a !== 8'hC3 || slot_a !== 2'd1 || cpu_clk_a !== hold_cpu || valid_a !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL freeze_hold t=%0d got bus=%h slot=%0d cpu=%b valid=%b want bus=c3 slot=1 cpu=%b valid=1",
                         t, bus_a, slot_a, cpu_clk_a, valid_a, hold_cpu);
            end
        end
        ena = 1'b1;
        tick();
        vectors++;
        if (slot_a !== 2'd2 || bus_a !== 8'h01 || cpu_clk_a !== ~hold_cpu) begin
            miscompares++;
            $display("[TB] FAIL freeze_resume got slot=%0d bus=%h cpu=%b want slot=2 bus=01 cpu=%b",
                     slot_a, bus_a, cpu_clk_a, ~hold_cpu);
        end
    endtask

    task automatic test_async_reset();
        align_a();
        addr_a = 16'h7E81;
        ctrl_a = 2'b11;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({cpu_clk_a, bus_a, slot_a, frame_a, valid_a, par_a} !== 14'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got cpu=%b bus=%h slot=%0d frame=%b valid=%b par=%b want all 0",
                     cpu_clk_a, bus_a, slot_a, frame_a, valid_a, par_a);
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        addr_a = 16'h4455;
        tick();
        vectors++;
        if (slot_a !== 2'd0 || frame_a !== 1'b1 || bus_a !== 8'h55) begin
            miscompares++;
            $display("[TB] FAIL reset_restart got slot=%0d frame=%b bus=%h want slot=0 frame=1 bus=55",
                     slot_a, frame_a, bus_a);
        end
    endtask

    task automatic test_parity();
        logic exp_par[3];
`ifdef BUS_PARITY_EN
        exp_par = '{1'b0, 1'b1, 1'b1};
`else
        exp_par = '{1'b0, 1'b0, 1'b0};
`endif
        align_a();
        addr_a = 16'h0103;
        ctrl_a = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (par_a !== exp_par[k]) begin
                miscompares++;
                $display("[TB] FAIL parity slot=%0d got %b want %b", k, par_a, exp_par[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            ena    = ($urandom_range(0, 3) != 0);
            addr_a = 16'($urandom);
            ctrl_a = 2'($urandom);
            addr_b = 12'($urandom);
            ctrl_b = 2'($urandom);
            tick();
            vectors++;
            if (bus_a !== e_bus[0] || slot_a !== 2'(e_slot[0]) || frame_a !== e_frame[0] ||
                valid_a !== e_valid[0] || cpu_clk_a !== e_cpu[0] || par_a !== e_par[0]) begin
                miscompares++;
                $display("[TB] FAIL random_a t=%0d got bus=%h slot=%0d frame=%b valid=%b cpu=%b par=%b want bus=%h slot=%0d frame=%b valid=%b cpu=%b par=%b",
                         t, bus_a, slot_a, frame_a, valid_a, cpu_clk_a, par_a,
                         e_bus[0], e_slot[0], e_frame[0], e_valid[0], e_cpu[0], e_par[0]);
            end
            vectors++;
            if (bus_b !== e_bus[1] || slot_b !== 2'(e_slot[1]) || frame_b !== e_frame[1] ||
                valid_b !== e_valid[1] || cpu_clk_b !== e_cpu[1] || par_b !== e_par[1]) begin
                miscompares++;
                $display("[TB] FAIL random_b t=%0d got bus=%h slot=%0d frame=%b valid=%b cpu=%b par=%b want bus=%h slot=%0d frame=%b valid=%b cpu=%b par=%b",
                         t, bus_b, slot_b, frame_b, valid_b, cpu_clk_b, par_b,
                         e_bus[1], e_slot[1], e_frame[1], e_valid[1], e_cpu[1], e_par[1]);
            end
        end
    endtask

    initial begin
        $display("[TB] starting cpu_bus_serializer bench");
        test_reset();
        test_frame();
        test_snapshot();
        test_freeze();
        test_async_reset();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
